// File: rtl/cnn_acc_ci_tm.sv
// ---------------------------------------------------------------------------
// cnn_acc_ci_tm
//   Accumulates per-channel kernel results across the input-channel dimension.
//   Each accepted beat carries PAR_CI signed lane values; NUM_PASS beats make
//   one output. The bias is added on the first beat, and the optional ReLU and
//   output saturation are applied on the last beat. The result is held in a
//   registered valid/ready output stage.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_in_valid     : input beat present
//   o_in_ready     : beat is accepted this cycle (when i_in_valid is also 1)
//   i_kernel_acc   : PAR_CI signed lanes, lane k at [k*AK_BW +: AK_BW]
//   i_bias         : signed bias, sampled on the first beat of a group
//   i_relu_en      : ReLU enable, sampled on the last beat of a group
//   i_clear        : synchronous abort of the partial group
//   o_busy         : a partial group is held
//   o_ot_valid     : result valid
//   i_ot_ready     : downstream accepts the result
//   o_ot_ci_acc    : signed result
//   o_ot_sat       : result was clamped
// ---------------------------------------------------------------------------

// Sign-extends one lane to the accumulator width.
module cnn_acc_ci_tm_lane #(
    parameter int AK_BW  = 20,
    parameter int ACI_BW = 24
) (
    input  logic [AK_BW-1:0]  i_lane,
    output logic [ACI_BW-1:0] o_ext
);
    assign o_ext = ACI_BW'($signed(i_lane));
endmodule

module cnn_acc_ci_tm #(
    parameter int AK_BW    = 20,
    parameter int PAR_CI   = 3,
    parameter int NUM_PASS = 4,
    parameter int ACI_BW   = 24,
    parameter int O_BW     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [PAR_CI*AK_BW-1:0] i_kernel_acc,
    input  logic [ACI_BW-1:0]       i_bias,
    input  logic                    i_relu_en,
    input  logic                    i_clear,
    output logic                    o_busy,
    output logic                    o_ot_valid,
    input  logic                    i_ot_ready,
    output logic [O_BW-1:0]         o_ot_ci_acc,
    output logic                    o_ot_sat
);
    localparam int PW = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;

    // Clamp bounds expressed at accumulator width for the range compare.
    localparam logic signed [ACI_BW-1:0] SAT_MAX =
        {{(ACI_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [ACI_BW-1:0] SAT_MIN =
        {{(ACI_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};
    localparam logic [O_BW-1:0] OUT_MAX = {1'b0, {(O_BW-1){1'b1}}};
    localparam logic [O_BW-1:0] OUT_MIN = {1'b1, {(O_BW-1){1'b0}}};

    logic [PW-1:0]                  r_pass;
    logic signed [ACI_BW-1:0]       r_acc;
    logic                           r_vld;
    logic [O_BW-1:0]                r_out;
    logic                           r_sat;

    logic [PAR_CI-1:0][ACI_BW-1:0]  w_lane_ext;
    logic signed [ACI_BW-1:0]       w_lane_sum;
    logic signed [ACI_BW-1:0]       w_base;
    logic signed [ACI_BW-1:0]       w_sum;
    logic signed [ACI_BW-1:0]       w_relu;
    logic [O_BW-1:0]                w_out;
    logic                           w_clamp;
    logic                           w_first;
    logic                           w_last;
    logic                           w_accept;

    genvar g;
    generate
        for (g = 0; g < PAR_CI; g++) begin : g_lane
            cnn_acc_ci_tm_lane #(
                .AK_BW  (AK_BW),
                .ACI_BW (ACI_BW)
            ) u_lane (
                .i_lane (i_kernel_acc[g*AK_BW +: AK_BW]),
                .o_ext  (w_lane_ext[g])
            );
        end
    endgenerate

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < PAR_CI; k++)
            w_lane_sum = w_lane_sum + $signed(w_lane_ext[k]);
    end

    assign w_first  = (r_pass == '0);
    assign w_last   = (r_pass == PW'(NUM_PASS-1));
    assign o_in_ready = !i_clear && (!r_vld || i_ot_ready);
    assign w_accept = i_in_valid && o_in_ready;

    // First beat restarts from the bias; later beats extend the running sum.
    // Overflow wraps at ACI_BW bits.
    assign w_base = w_first ? $signed(i_bias) : r_acc;
    assign w_sum  = w_base + w_lane_sum;

    // ReLU ahead of saturation, so a clamped negative can only occur with ReLU off.
    assign w_relu = (i_relu_en && w_sum[ACI_BW-1]) ? '0 : w_sum;

    always_comb begin
        w_clamp = 1'b0;
        w_out   = w_relu[O_BW-1:0];
        if (w_relu > SAT_MAX) begin
            w_clamp = 1'b1;
            w_out   = OUT_MAX;
        end else if (w_relu < SAT_MIN) begin
            w_clamp = 1'b1;
            w_out   = OUT_MIN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pass <= '0;
            r_acc  <= '0;
        end else if (i_clear) begin
            r_pass <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_pass <= w_last ? '0 : r_pass + PW'(1);
            r_acc  <= w_sum;
        end
    end

    // Output stage: a new last beat may load in the same cycle the previous
    // result is handshaken, so there is no bubble between outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= 1'b0;
            r_out <= '0;
            r_sat <= 1'b0;
        end else if (w_accept && w_last) begin
            r_vld <= 1'b1;
            r_out <= w_out;
            r_sat <= w_clamp;
        end else if (i_ot_ready) begin
            r_vld <= 1'b0;
        end
    end

    assign o_busy      = (r_pass != '0);
    assign o_ot_valid  = r_vld;
    assign o_ot_ci_acc = r_out;
    assign o_ot_sat    = r_sat;
endmodule

// File: tb/tb_cnn_acc_ci_tm.sv
module tb_cnn_acc_ci_tm;
    localparam int AK_BW    = 20;
    localparam int PAR_CI   = 3;
    localparam int NUM_PASS = 4;
    localparam int ACI_BW   = 24;
    localparam int O_BW     = 16;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    i_in_valid;
    logic                    o_in_ready;
    logic [PAR_CI*AK_BW-1:0] i_kernel_acc;
    logic [ACI_BW-1:0]       i_bias;
    logic                    i_relu_en;
    logic                    i_clear;
    logic                    o_busy;
    logic                    o_ot_valid;
    logic                    i_ot_ready;
    logic [O_BW-1:0]         o_ot_ci_acc;
    logic                    o_ot_sat;

    int n_chk = 0;
    int n_err = 0;

    cnn_acc_ci_tm #(
        .AK_BW(AK_BW), .PAR_CI(PAR_CI), .NUM_PASS(NUM_PASS),
        .ACI_BW(ACI_BW), .O_BW(O_BW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_kernel_acc (i_kernel_acc),
        .i_bias       (i_bias),
        .i_relu_en    (i_relu_en),
        .i_clear      (i_clear),
        .o_busy       (o_busy),
        .o_ot_valid   (o_ot_valid),
        .i_ot_ready   (i_ot_ready),
        .o_ot_ci_acc  (o_ot_ci_acc),
        .o_ot_sat     (o_ot_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint res();
        return longint'($signed(o_ot_ci_acc));
    endfunction

    task automatic set_lanes(input int a, input int b, input int c);
        i_kernel_acc[0*AK_BW +: AK_BW] = AK_BW'(a);
        i_kernel_acc[1*AK_BW +: AK_BW] = AK_BW'(b);
        i_kernel_acc[2*AK_BW +: AK_BW] = AK_BW'(c);
    endtask

    // Presents one beat for one clock edge; returns #1 after that edge.
    task automatic beat(input int a, input int b, input int c,
                        input int bias, input bit relu);
        set_lanes(a, b, c);
        i_bias     = ACI_BW'(bias);
        i_relu_en  = relu;
        i_in_valid = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    longint held;

    initial begin
        reset_n    = 1'b0;
        i_in_valid = 1'b0;
        i_kernel_acc = '0;
        i_bias     = '0;
        i_relu_en  = 1'b0;
        i_clear    = 1'b0;
        i_ot_ready = 1'b1;
        #23;
        chk("rst_valid", o_ot_valid, 0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_data",  res(), 0);
        chk("rst_sat",   o_ot_sat, 0);
        chk("rst_ready", o_in_ready, 1);
        reset_n = 1'b1;
        idle();

        // basic: 4 x (1+2+3) + bias 10 = 34; bias on later beats must be ignored
        beat(1, 2, 3, 10, 1'b0);
        chk("basic_busy", o_busy, 1);
        beat(1, 2, 3, 999, 1'b0);
        beat(1, 2, 3, 999, 1'b0);
        chk("basic_no_early_valid", o_ot_valid, 0);
        beat(1, 2, 3, 999, 1'b0);
        chk("basic_valid", o_ot_valid, 1);
        chk("basic_data",  res(), 34);
        chk("basic_sat",   o_ot_sat, 0);
        chk("basic_busy_end", o_busy, 0);
        idle();
        chk("basic_valid_drop", o_ot_valid, 0);

        // saturation: 12 x (2^19-1) = 6291444 -> 32767
        for (int i = 0; i < NUM_PASS; i++) beat(524287, 524287, 524287, 0, 1'b0);
        chk("satp_data", res(), 32767);
        chk("satp_sat",  o_ot_sat, 1);
        // 12 x -2^19 = -6291456 -> -32768
        for (int i = 0; i < NUM_PASS; i++) beat(-524288, -524288, -524288, 0, 1'b0);
        chk("satn_data", res(), -32768);
        chk("satn_sat",  o_ot_sat, 1);

        // ReLU: bias -100, lanes 0; enable sampled only on the last beat
        beat(0, 0, 0, -100, 1'b0);
        beat(0, 0, 0, 0, 1'b0);
        beat(0, 0, 0, 0, 1'b0);
        beat(0, 0, 0, 0, 1'b1);
        chk("relu_on_data", res(), 0);
        chk("relu_on_sat",  o_ot_sat, 0);
        beat(0, 0, 0, -100, 1'b1);
        beat(0, 0, 0, 0, 1'b1);
        beat(0, 0, 0, 0, 1'b1);
        beat(0, 0, 0, 0, 1'b0);
        chk("relu_off_data", res(), -100);
        chk("relu_off_sat",  o_ot_sat, 0);

        // continuous stream: 12 then 24, one output every 4 cycles
        for (int i = 0; i < 8; i++) begin
            chk("stream_ready", o_in_ready, 1);
            beat(i < 4 ? 1 : 2, i < 4 ? 1 : 2, i < 4 ? 1 : 2, 0, 1'b0);
            if (i == 3) begin
                chk("stream_v0", o_ot_valid, 1);
                chk("stream_d0", res(), 12);
            end
            if (i == 4) chk("stream_drop", o_ot_valid, 0);
        end
        chk("stream_v1", o_ot_valid, 1);
        chk("stream_d1", res(), 24);

        // backpressure: group (3-1+2)*4 + 5 = 21, held while i_ot_ready=0
        for (int i = 0; i < 3; i++) beat(3, -1, 2, i == 0 ? 5 : 0, 1'b0);
        i_ot_ready = 1'b0;
        beat(3, -1, 2, 0, 1'b0);
        chk("bp_valid", o_ot_valid, 1);
        chk("bp_data",  res(), 21);
        held = res();
        set_lanes(9, 9, 9);
        i_bias = ACI_BW'(77);
        i_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", o_in_ready, 0);
            idle();
            chk("bp_hold_valid", o_ot_valid, 1);
            chk("bp_hold_data",  res(), held);
        end
        i_in_valid = 1'b0;
        chk("bp_no_accept", o_busy, 0);
        // first beat of next group accepted in the handshake cycle: 9*12 + 1 = 109
        i_ot_ready = 1'b1;
        beat(9, 9, 9, 1, 1'b0);
        chk("bp_release_valid", o_ot_valid, 0);
        chk("bp_release_busy",  o_busy, 1);
        for (int i = 0; i < 3; i++) beat(9, 9, 9, 0, 1'b0);
        chk("bp_next_data", res(), 109);
        idle();

        // clear: partial group and the beat in the clear cycle are dropped
        beat(5, 5, 5, 7, 1'b0);
        beat(5, 5, 5, 0, 1'b0);
        set_lanes(100, 100, 100);
        i_clear = 1'b1;
        i_in_valid = 1'b1;
        #1;
        chk("clr_ready", o_in_ready, 0);
        idle();
        i_clear = 1'b0;
        i_in_valid = 1'b0;
        chk("clr_busy", o_busy, 0);
        for (int i = 0; i < 4; i++) beat(1, 1, 1, 0, 1'b0);
        chk("clr_data", res(), 12);
        chk("clr_sat",  o_ot_sat, 0);

        // reset mid-group: same result afterwards, outputs forced to 0
        beat(5, 5, 5, 7, 1'b0);
        beat(5, 5, 5, 0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", o_ot_valid, 0);
        chk("mrst_data",  res(), 0);
        chk("mrst_busy",  o_busy, 0);
        chk("mrst_sat",   o_ot_sat, 0);
        idle();
        reset_n = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) beat(1, 1, 1, 0, 1'b0);
        chk("mrst_out_valid", o_ot_valid, 1);
        chk("mrst_out_data",  res(), 12);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
